// File: rtl/memory_access.sv
// RISC-V MEM stage: branch resolution, req/ack data-memory access with stall and
// timeout, load alignment/extension, store lane generation, and MEM/WB registers.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] branch_addr_from_execution,
    input  logic [31:0] result_from_execution,
    input  logic [31:0] rs2_data_from_execution,
    input  logic        equal_from_execution,
    input  logic        greater_from_execution,
    input  logic        lesser_from_execution,
    input  logic [2:0]  funct3_from_execution,
    input  logic [4:0]  rd_from_execution,
    input  logic        write_reg_from_execution,
    input  logic        select_from_execution,
    input  logic        read_from_execution,
    input  logic        write_from_execution,
    input  logic        branch_from_execution,
    input  logic        u_branch_from_execution,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall_from_memory,
    output logic        pc_src_from_memory,
    output logic [31:0] branch_target_from_memory,
    output logic [31:0] result_from_memory,
    output logic [4:0]  rd_from_memory,
    output logic        write_reg_from_memory,
    output logic        misalign_from_memory,
    output logic        mem_error_from_memory
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d, we_q, we_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       alo_q, alo_d;
    logic             sel_q, sel_d;
    logic [31:0]      result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             misalign_q, misalign_d;
    logic             err_q, err_d;

    logic        stall;
    logic        cond, taken;
    logic [1:0]  a;
    logic        mem_op, misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        unique case (funct3_from_execution)
            3'b000:         cond = equal_from_execution;
            3'b001:         cond = !equal_from_execution;
            3'b100, 3'b110: cond = lesser_from_execution;
            3'b101, 3'b111: cond = !lesser_from_execution;
            default:        cond = 1'b0;
        endcase
        taken = u_branch_from_execution | (branch_from_execution & cond);
    end

    // Store lanes and alignment check from the live EX/MEM inputs; size code 11 is treated as word.
    always_comb begin
        a          = result_from_execution[1:0];
        mem_op     = read_from_execution | write_from_execution;
        misaligned = ((funct3_from_execution[1:0] == 2'b01) & a[0]) |
                     (funct3_from_execution[1] & (a != 2'b00));
        unique case (funct3_from_execution[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data_from_execution[7:0]}};
                st_be    = 4'b0001 << a;
            end
            2'b01: begin
                st_wdata = {2{rs2_data_from_execution[15:0]}};
                st_be    = a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = rs2_data_from_execution;
                st_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[8*alo_q +: 8];
        ld_half = alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (f3_q[1:0])
            2'b00:   ld_data = f3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = f3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        alo_d      = alo_q;
        sel_d      = sel_q;
        result_d   = result_q;
        rd_d       = '0;
        wr_d       = 1'b0;
        misalign_d = 1'b0;
        err_d      = err_q;
        stall      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op && misaligned) begin
                    misalign_d = 1'b1;
                end else if (mem_op) begin
                    stall   = 1'b1;
                    state_d = ACCESS;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = write_from_execution;
                    addr_d  = {result_from_execution[31:2], 2'b00};
                    wdata_d = st_wdata;
                    be_d    = st_be;
                    f3_d    = funct3_from_execution;
                    alo_d   = a;
                    sel_d   = select_from_execution;
                end else begin
                    result_d = result_from_execution;
                    rd_d     = rd_from_execution;
                    wr_d     = write_reg_from_execution;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    result_d = sel_q ? ld_data : result_from_execution;
                    rd_d     = rd_from_execution;
                    wr_d     = write_reg_from_execution;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            alo_q      <= '0;
            sel_q      <= 1'b0;
            result_q   <= '0;
            rd_q       <= '0;
            wr_q       <= 1'b0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            alo_q      <= alo_d;
            sel_q      <= sel_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
        end
    end

    assign dmem_req                  = req_q;
    assign dmem_we                   = we_q;
    assign dmem_addr                 = addr_q;
    assign dmem_wdata                = wdata_q;
    assign dmem_be                   = be_q;
    assign stall_from_memory         = stall;
    assign pc_src_from_memory        = taken & !stall;
    assign branch_target_from_memory = branch_addr_from_execution;
    assign result_from_memory        = result_q;
    assign rd_from_memory            = rd_q;
    assign write_reg_from_memory     = wr_q;
    assign misalign_from_memory      = misalign_q;
    assign mem_error_from_memory     = err_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access with a short timeout.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] branch_addr, result_ex, rs2;
    logic        equal, greater, lesser;
    logic [2:0]  funct3;
    logic [4:0]  rd_ex;
    logic        write_reg, sel, rd_en, wr_en, branch, u_branch;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        stall, pc_src;
    logic [31:0] target, result_mem;
    logic [4:0]  rd_mem;
    logic        wr_mem, misalign, mem_error;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .branch_addr_from_execution(branch_addr),
        .result_from_execution(result_ex),
        .rs2_data_from_execution(rs2),
        .equal_from_execution(equal),
        .greater_from_execution(greater),
        .lesser_from_execution(lesser),
        .funct3_from_execution(funct3),
        .rd_from_execution(rd_ex),
        .write_reg_from_execution(write_reg),
        .select_from_execution(sel),
        .read_from_execution(rd_en),
        .write_from_execution(wr_en),
        .branch_from_execution(branch),
        .u_branch_from_execution(u_branch),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .stall_from_memory(stall),
        .pc_src_from_memory(pc_src),
        .branch_target_from_memory(target),
        .result_from_memory(result_mem),
        .rd_from_memory(rd_mem),
        .write_reg_from_memory(wr_mem),
        .misalign_from_memory(misalign),
        .mem_error_from_memory(mem_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        branch_addr = '0; result_ex = '0; rs2 = '0;
        equal = 0; greater = 0; lesser = 0; funct3 = '0; rd_ex = '0;
        write_reg = 0; sel = 0; rd_en = 0; wr_en = 0; branch = 0; u_branch = 0;
        dmem_rdata = '0; dmem_ack = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, pc_src,
             result_mem, rd_mem, wr_mem, misalign, mem_error} !== '0) begin
            n_bad++;
            $display("FAIL reset: outputs req=%b res=%h rd=%h wr=%b err=%b, all required 0",
                     dmem_req, result_mem, rd_mem, wr_mem, mem_error);
        end
    endtask

    task automatic test_add();
        result_ex = 32'h1234; rd_ex = 5; write_reg = 1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL add_stall: got %b want 0", stall); end
        tick();
        n_cmp++;
        if ({result_mem, rd_mem, wr_mem} !== {32'h1234, 5'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL add_wb: got %h/%0d/%b want 00001234/5/1", result_mem, rd_mem, wr_mem);
        end
        clear_inputs();
        dmem_ack = 1;  // an ack while idle must not start anything
        tick();
        n_cmp++;
        if ({dmem_req, stall} !== 2'b00) begin
            n_bad++; $display("FAIL idle_ack: req/stall got %b%b want 00", dmem_req, stall);
        end
        dmem_ack = 0;
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] exp);
        int unsigned stalls = 0;
        clear_inputs();
        rd_en = 1; sel = 1; result_ex = 32'h103; funct3 = f3; rd_ex = 7; write_reg = 1;
        #1;
        if (stall) stalls++;
        tick();
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, wr_mem} !== {1'b1, 1'b0, 32'h100, 4'b1000, 1'b0}) begin
            n_bad++;
            $display("FAIL load_req: req=%b we=%b addr=%h be=%b wr=%b want 1 0 00000100 1000 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, wr_mem);
        end
        if (stall) stalls++;
        tick();
        dmem_rdata = 32'h80FF_FFFF; dmem_ack = 1;
        #1;
        if (stall) stalls++;
        n_cmp++;
        if (stalls != 2) begin n_bad++; $display("FAIL load_stalls: got %0d want 2", stalls); end
        tick();
        dmem_ack = 0;
        clear_inputs();
        n_cmp++;
        if ({result_mem, rd_mem, wr_mem, dmem_req} !== {exp, 5'd7, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL load_f3_%0d: got %h/%0d/%b req=%b want %h/7/1 req=0",
                     f3, result_mem, rd_mem, wr_mem, dmem_req, exp);
        end
    endtask

    task automatic test_store();
        clear_inputs();
        wr_en = 1; result_ex = 32'h102; rs2 = 32'h0000_ABCD; funct3 = 3'b001;
        tick();
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata[31:16]} !==
            {1'b1, 1'b1, 32'h100, 4'b1100, 16'hABCD}) begin
            n_bad++;
            $display("FAIL store_bus: req=%b we=%b addr=%h be=%b wdata=%h want 1 1 00000100 1100 ABCDxxxx",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        dmem_ack = 1;
        tick();
        dmem_ack = 0;
        n_cmp++;
        if ({dmem_req, result_mem, wr_mem} !== {1'b0, 32'h102, 1'b0}) begin
            n_bad++;
            $display("FAIL store_done: req=%b res=%h wr=%b want 0 00000102 0", dmem_req, result_mem, wr_mem);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_misalign();
        clear_inputs();
        rd_en = 1; sel = 1; funct3 = 3'b010; result_ex = 32'h101; rd_ex = 3; write_reg = 1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL misalign_stall: got %b want 0", stall); end
        tick();
        clear_inputs();
        n_cmp++;
        if ({misalign, dmem_req, wr_mem, rd_mem} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL misalign: pulse=%b req=%b wr=%b rd=%0d want 1 0 0 0", misalign, dmem_req, wr_mem, rd_mem);
        end
        tick();
        n_cmp++;
        if (misalign !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse_end: got %b want 0", misalign); end
    endtask

    task automatic test_branch();
        clear_inputs();
        branch = 1; branch_addr = 32'h200; lesser = 1; funct3 = 3'b100;
        #1;
        n_cmp++;
        if ({pc_src, target} !== {1'b1, 32'h200}) begin
            n_bad++; $display("FAIL blt: pc_src=%b target=%h want 1 00000200", pc_src, target);
        end
        funct3 = 3'b101;
        #1;
        n_cmp++;
        if (pc_src !== 1'b0) begin n_bad++; $display("FAIL bge: pc_src got %b want 0", pc_src); end
        funct3 = 3'b001; equal = 0;
        #1;
        n_cmp++;
        if (pc_src !== 1'b1) begin n_bad++; $display("FAIL bne: pc_src got %b want 1", pc_src); end
        funct3 = 3'b010;
        #1;
        n_cmp++;
        if (pc_src !== 1'b0) begin n_bad++; $display("FAIL bad_f3: pc_src got %b want 0", pc_src); end
        branch = 0; u_branch = 1;
        #1;
        n_cmp++;
        if (pc_src !== 1'b1) begin n_bad++; $display("FAIL jal: pc_src got %b want 1", pc_src); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int unsigned stalls = 0;
        clear_inputs();
        rd_en = 1; sel = 1; funct3 = 3'b010; result_ex = 32'h40; rd_ex = 9; write_reg = 1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (!stall) break;
            stalls++;
            tick();
        end
        n_cmp++;
        if (stalls != 4) begin n_bad++; $display("FAIL timeout_stalls: got %0d want 4", stalls); end
        tick();
        clear_inputs();
        n_cmp++;
        if ({mem_error, dmem_req, wr_mem} !== {1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL timeout_abort: err=%b req=%b wr=%b want 1 0 0", mem_error, dmem_req, wr_mem);
        end
        tick();
        tick();
        n_cmp++;
        if (mem_error !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want 1", mem_error); end
        test_reset();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_add();
        test_load(3'b000, 32'hFFFF_FF80);
        test_load(3'b100, 32'h0000_0080);
        test_store();
        test_misalign();
        test_branch();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
